// File: rtl/ieee_conv_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational IEEE converter between two requesters.
// Optional macro IEEE_ARB_ZERO_BYPASS_EN: all-zero operands skip the converter wait.
module ieee_conv_arbiter #(
  parameter int CONV_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_a,
  input  logic [4:0]  req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_a,
  input  logic [4:0]  req1_b,
  output logic [4:0]  conv_in1,
  output logic [4:0]  conv_in2,
  input  logic [31:0] conv_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        busy
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0] state;
  logic       ptr;
  logic [3:0] cnt;
  logic       grant_any;
  logic       grant_id;
  logic [4:0] win_a;
  logic [4:0] win_b;
  logic       zero_ops;

  // Ready is gated by rst so nothing reads as accepted while reset is held.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (state == IDLE && !rst) begin
      if (req0_valid && req1_valid) begin
        grant_any = 1'b1;
        grant_id  = ptr;
      end else if (req0_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b0;
      end else if (req1_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  assign req0_ready = grant_any && !grant_id;
  assign req1_ready = grant_any && grant_id;
  assign win_a      = grant_id ? req1_a : req0_a;
  assign win_b      = grant_id ? req1_b : req0_b;
  assign busy       = (state != IDLE);

`ifdef IEEE_ARB_ZERO_BYPASS_EN
  assign zero_ops = (win_a == 5'd0) && (win_b == 5'd0);
`else
  assign zero_ops = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      cnt       <= 4'd0;
      conv_in1  <= 5'd0;
      conv_in2  <= 5'd0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            conv_in1 <= win_a;
            conv_in2 <= win_b;
            rsp_id   <= grant_id;
            if (zero_ops) begin
              rsp_data  <= 32'd0;
              rsp_valid <= 1'b1;
              cnt       <= 4'd0;
              state     <= RESP;
            end else begin
              cnt   <= 4'(CONV_CYCLES);
              state <= CONV;
            end
          end
        end
        CONV: begin
          // The accept edge counts as the first settle cycle, so capture happens at cnt==1.
          if (cnt == 4'd1) begin
            rsp_data  <= conv_out;
            rsp_valid <= 1'b1;
            cnt       <= 4'd0;
            state     <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ptr       <= ~rsp_id;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ieee_conv_arbiter.sv
// Self-checking bench for ieee_conv_arbiter: vector table, corner sequences, randomized
// transactions against a transaction-level round-robin model.
module tb_ieee_conv_arbiter;
  localparam int CONV_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_a, req0_b, req1_a, req1_b;
  logic [4:0]  conv_in1, conv_in2;
  logic [31:0] conv_out;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_data;
  logic        busy;

  int tests = 0;
  int fails = 0;
  logic mptr;

  always #5 clk = ~clk;

  assign conv_out = {22'd0, conv_in1, conv_in2};

  ieee_conv_arbiter #(.CONV_CYCLES(CONV_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .conv_in1(conv_in1), .conv_in2(conv_in2), .conv_out(conv_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy)
  );

  typedef struct {
    logic       v0;
    logic [4:0] a0;
    logic [4:0] b0;
    logic       v1;
    logic [4:0] a1;
    logic [4:0] b1;
    logic       exp_id;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  function automatic int exp_lat(input logic [4:0] a, input logic [4:0] b);
`ifdef IEEE_ARB_ZERO_BYPASS_EN
    if (a == 5'd0 && b == 5'd0) return 1;
`endif
    return CONV_CYCLES + 1;
  endfunction

  function automatic logic [63:0] idle_outs();
    return {16'd0, req0_ready, req1_ready, conv_in1, conv_in2, rsp_valid, rsp_id, busy, rsp_data};
  endfunction

  // One full transaction with rsp_ready held high; latency counts the accept edge as edge 1.
  task automatic run_txn(input logic v0, input logic [4:0] a0, input logic [4:0] b0,
                         input logic v1, input logic [4:0] a1, input logic [4:0] b1,
                         output logic granted, output logic [1:0] rdy, output int lat,
                         output logic got_id, output logic [31:0] got_data);
    int n;
    granted = 1'b0; rdy = 2'b00; lat = 0; got_id = 1'b0; got_data = 32'd0;
    @(negedge clk);
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    rsp_ready = 1'b1;
    #1;
    n = 0;
    while (!(req0_ready || req1_ready) && n < 10) begin
      @(negedge clk); #1; n++;
    end
    if (!(req0_ready || req1_ready)) return;
    granted = 1'b1;
    rdy = {req1_ready, req0_ready};
    @(posedge clk); #1;
    lat = 1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    got_id = rsp_id; got_data = rsp_data;
    @(posedge clk); #1;
  endtask

  task automatic txn_check(input string name, input logic v0, input logic [4:0] a0, input logic [4:0] b0,
                           input logic v1, input logic [4:0] a1, input logic [4:0] b1,
                           input logic exp_id, input logic [31:0] exp_data);
    logic granted, got_id;
    logic [1:0] rdy;
    int lat;
    logic [31:0] got_data;
    logic [4:0] wa, wb;
    run_txn(v0, a0, b0, v1, a1, b1, granted, rdy, lat, got_id, got_data);
    check({name, " granted"}, 64'(granted), 64'd1);
    check({name, " ready"}, 64'(rdy), exp_id ? 64'd2 : 64'd1);
    check({name, " id"}, 64'(got_id), 64'(exp_id));
    check({name, " data"}, 64'(got_data), 64'(exp_data));
    wa = exp_id ? a1 : a0;
    wb = exp_id ? b1 : b0;
    check({name, " latency"}, 64'(lat), 64'(exp_lat(wa, wb)));
    check({name, " conv_in held"}, 64'({conv_in1, conv_in2, rsp_valid, busy}), 64'({wa, wb, 2'b00}));
    mptr = ~exp_id;
  endtask

  initial begin
    logic v0, v1, eid;
    logic [4:0] a0, b0, a1, b1, wa, wb;
    logic [63:0] acc;
    int n;

    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 5'd0; req0_b = 5'd0; req1_a = 5'd0; req1_b = 5'd0;
    mptr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("idle outs cyc%0d", i), idle_outs(), 64'd0);
    end

    vecs[0] = '{1'b1, 5'd9, 5'd8, 1'b1, 5'd7, 5'd6, 1'b0, 32'h0000_0128};
    vecs[1] = '{1'b1, 5'd9, 5'd8, 1'b1, 5'd7, 5'd6, 1'b1, 32'h0000_00E6};
    vecs[2] = '{1'b1, 5'd9, 5'd8, 1'b1, 5'd7, 5'd6, 1'b0, 32'h0000_0128};
    vecs[3] = '{1'b1, 5'd7, 5'd6, 1'b0, 5'd0, 5'd0, 1'b0, 32'h0000_00E6};
    vecs[4] = '{1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 5'd4, 1'b1, 32'h0000_0064};
    vecs[5] = '{1'b1, 5'd1, 5'd2, 1'b1, 5'd31, 5'd31, 1'b0, 32'h0000_0022};
    vecs[6] = '{1'b1, 5'd31, 5'd31, 1'b0, 5'd1, 5'd1, 1'b0, 32'h0000_03FF};
    vecs[7] = '{1'b0, 5'd5, 5'd5, 1'b1, 5'd0, 5'd0, 1'b1, 32'h0000_0000};
    for (int i = 0; i < 8; i++)
      txn_check($sformatf("vec%0d", i), vecs[i].v0, vecs[i].a0, vecs[i].b0,
                vecs[i].v1, vecs[i].a1, vecs[i].b1, vecs[i].exp_id, vecs[i].exp_data);

    // Backpressure: response held 10 cycles while both requesters wait.
    @(negedge clk);
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 5'd5; req0_b = 5'd5;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_a = 5'd2; req1_b = 5'd2;
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("bp rsp_valid rose", 64'(rsp_valid), 64'd1);
    acc = 64'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      acc |= 64'({rsp_valid, rsp_id, rsp_data, req0_ready, req1_ready, busy}) ^
             64'({1'b1, 1'b0, 32'h0000_00A5, 1'b0, 1'b0, 1'b1});
    end
    check("bp held stable 10 cyc", acc, 64'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp released", 64'({rsp_valid, busy}), 64'd0);
    mptr = 1'b1;

    // Mid-operation reset in CONV.
    @(negedge clk);
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 5'd9; req0_b = 5'd8;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    check("midrst in conv", 64'({busy, rsp_valid}), 64'b10);
    rst = 1'b1;
    #1;
    check("midrst async outs", idle_outs(), 64'd0);
    @(negedge clk); rst = 1'b0;
    acc = 64'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      acc |= 64'({rsp_valid, busy});
    end
    check("midrst no rsp", acc, 64'd0);
    mptr = 1'b0;
    txn_check("post rst req1", 1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 5'd6, 1'b1, 32'h0000_00E6);

    // Randomized transactions against the round-robin model.
    for (int i = 0; i < 40; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      a0 = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      b0 = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      a1 = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      b1 = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      if (i % 7 == 0) begin a0 = 5'd0; b0 = 5'd0; end
      eid = (v0 && v1) ? mptr : v1;
      wa = eid ? a1 : a0;
      wb = eid ? b1 : b0;
      txn_check($sformatf("rand%0d", i), v0, a0, b0, v1, a1, b1, eid, 32'(wa) * 32 + 32'(wb));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ieee_conv_arbiter.md
# ieee_conv_arbiter

Round-robin arbiter and sequencer that shares one combinational `IEEE` float converter between two requesters. Each requester presents a pair of 5-bit operands with a valid/ready handshake. The block grants one requester, drives the converter's `in1`/`in2` from registers, and waits a programmable settle time. It then captures the 32-bit converter `out` and returns it, tagged with the requester id, on a valid/ready response port.

## Interface
Parameters:
- `CONV_CYCLES`, default 2: cycles operands are held on the converter before capture; legal range 1..15.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0_valid` in 1: requester 0 has operands.
- `req0_ready` out 1: requester 0 accepted this cycle.
- `req0_a` in 5: requester 0 operand for `in1`.
- `req0_b` in 5: requester 0 operand for `in2`.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`: same as requester 0, for requester 1.
- `conv_in1` out 5: registered drive to converter `in1`.
- `conv_in2` out 5: registered drive to converter `in2`.
- `conv_out` in 32: converter result.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer takes result.
- `rsp_id` out 1: requester that owns `rsp_data`.
- `rsp_data` out 32: captured converter result.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, CONV, RESP.
- IDLE: the winner is chosen from the valid requesters using the round-robin pointer `ptr`.
  - The winner's `reqN_ready` is asserted combinationally in the same cycle; the loser's ready stays 0.
  - If only one requester is valid, it wins regardless of `ptr`.
  - At the accept edge: `conv_in1`/`conv_in2` <= winner's a/b, `rsp_id` <= winner id, counter <= `CONV_CYCLES`, state -> CONV.
- CONV: the counter decrements each cycle.
  - On the edge where the counter equals 1: `rsp_data` <= `conv_out`, `rsp_valid` <= 1, state -> RESP.
- RESP: `rsp_valid`, `rsp_data` and `rsp_id` are held stable until `rsp_ready` = 1.
  - On the handshake edge: `rsp_valid` <= 0, `ptr` <= ~`rsp_id`, state -> IDLE.
- `conv_in1`/`conv_in2` keep their last value in IDLE; they do not return to zero.
- No `reqN_ready` is asserted outside IDLE, so no new request is accepted in CONV or RESP.
- `busy` = (state != IDLE).

## Timing
- Reset values:
  - Outputs: `req0_ready`=0, `req1_ready`=0, `conv_in1`=0, `conv_in2`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `busy`=0.
  - Internal: state = IDLE, `ptr`=0 (requester 0 is favoured first), counter=0.
- Latency: `rsp_valid` rises `CONV_CYCLES`+1 edges after the accept edge.
- Minimum spacing between accepts is `CONV_CYCLES`+2 cycles (IDLE, CONV×N, RESP with `rsp_ready` held high).
- Simultaneous valid in IDLE: the requester equal to `ptr` wins.
- A requester may drop valid before it is granted; no request is latched until ready=1.
- `rsp_ready` asserted before RESP is ignored.
- `rst` asserted in CONV or RESP: the in-flight result is discarded and all outputs go to their reset values immediately (asynchronously).

## Configuration
- `IEEE_ARB_ZERO_BYPASS_EN`
- Defined: when the accepted operands are both 0, the block goes IDLE -> RESP directly with `rsp_data`=32'h0000_0000 and skips CONV. `rsp_valid` rises 1 edge after accept. `conv_in1`/`conv_in2` are still loaded with 0.
- Undefined: zero operands take the normal CONV path with the full latency, and `rsp_data` = `conv_out`.

## Test plan
The bench converter stub drives `conv_out` = {22'd0, `conv_in1`, `conv_in2`}. `CONV_CYCLES`=2 unless stated.
- Reset then idle: all outputs 0 and `busy`=0 for 5 cycles with no valids.
- Single request: req0 a=7, b=6 -> `req0_ready` for 1 cycle; `rsp_valid` 3 edges later; `rsp_data`=32'h0000_00E6, `rsp_id`=0.
- Contention:
  - req0 (9,8) and req1 (7,6) both held valid, `rsp_ready`=1 -> first response id 0 with 32'h0000_0128, then id 1 with 32'h0000_00E6.
  - Then a second pair -> req0 again (alternation).
- Backpressure: `rsp_ready`=0 for 10 cycles in RESP -> `rsp_valid`, data and id stable; both ready outputs 0; `busy`=1.
- Zero operands (0,0):
  - With `IEEE_ARB_ZERO_BYPASS_EN` -> `rsp_valid` 1 edge after accept, data 0.
  - Without the macro -> 3 edges after accept, data 0.
- Mid-operation reset: assert `rst` in CONV -> `rsp_valid` never rises; after release the next req1 (7,6) completes normally with `rsp_id`=1.
